// File: rtl/display_scan_ctrl.sv
// display_scan_ctrl: time-multiplexing scan scheduler for an N-digit 7-segment display.
// Each digit slot starts with a short blanking gap and then shows the digit.
// New values come in through a ready/valid handshake and are committed only at frame boundaries.
// Optional feature: define LZ_SUPPRESS_EN to keep leading-zero digits dark.
module display_scan_ctrl #(
    parameter int unsigned CLK_HZ       = 25_000_000,
    parameter int unsigned REFRESH_HZ   = 1_000,
    parameter int unsigned N_DIGITS     = 4,
    parameter int unsigned BLANK_CYCLES = 250
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  load_valid,
    output logic                  load_ready,
    input  logic [4*N_DIGITS-1:0] load_data,
    output logic [3:0]            digit_code,
    output logic [N_DIGITS-1:0]   digit_en,
    output logic                  frame_done
);

    localparam int unsigned SLOT = CLK_HZ / REFRESH_HZ;
    localparam int unsigned CntW = $clog2(SLOT + 1);
    localparam int unsigned IdxW = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;

    localparam logic [CntW-1:0] SlotLast  = CntW'(SLOT - 1);
    localparam logic [CntW-1:0] BlankLast = CntW'((BLANK_CYCLES == 0) ? 0 : BLANK_CYCLES - 1);
    localparam logic [IdxW-1:0] IdxLast   = IdxW'(N_DIGITS - 1);

    if (BLANK_CYCLES >= SLOT) begin : g_bad_blank
        $error("display_scan_ctrl: BLANK_CYCLES must be smaller than CLK_HZ/REFRESH_HZ");
    end
    if (N_DIGITS == 0 || N_DIGITS > 8) begin : g_bad_digits
        $error("display_scan_ctrl: N_DIGITS must be in 1..8");
    end

    typedef enum logic [0:0] {StBlank, StShow} state_e;

    state_e                state_q, state_d;
    logic [CntW-1:0]       cnt_q, cnt_d;
    logic [IdxW-1:0]       idx_q, idx_d;
    logic [4*N_DIGITS-1:0] active_q, active_d;
    logic [4*N_DIGITS-1:0] shadow_q, shadow_d;
    logic                  pending_q, pending_d;
    logic [N_DIGITS-1:0]   digit_en_q, digit_en_d;
    logic [3:0]            digit_code_q, digit_code_d;
    logic                  frame_done_q, frame_done_d;

    logic                  slot_end;
    logic                  wrap;
    logic                  commit;
    logic                  xfer;
    logic [N_DIGITS-1:0]   show_mask;

    // Slot sequencing: blank gap, then show, then advance to the next digit.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q + 1'b1;
        idx_d    = idx_q;
        slot_end = 1'b0;
        wrap     = 1'b0;
        unique case (state_q)
            StBlank: begin
                if (BLANK_CYCLES == 0 || cnt_q == BlankLast) begin
                    state_d = StShow;
                end
            end
            StShow: begin
                if (cnt_q == SlotLast) begin
                    slot_end = 1'b1;
                    cnt_d    = '0;
                    // With no blanking gap the next slot starts directly in SHOW.
                    state_d  = (BLANK_CYCLES == 0) ? StShow : StBlank;
                    if (idx_q == IdxLast) begin
                        idx_d = '0;
                        wrap  = 1'b1;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            default: state_d = StBlank;
        endcase
    end

    // Handshake and frame-boundary commit; a commit can never coincide with a transfer.
    always_comb begin
        xfer      = load_valid && !pending_q;
        commit    = wrap && pending_q;
        active_d  = commit ? shadow_q : active_q;
        shadow_d  = xfer ? load_data : shadow_q;
        pending_d = pending_q;
        if (commit) begin
            pending_d = 1'b0;
        end else if (xfer) begin
            pending_d = 1'b1;
        end
    end

`ifdef LZ_SUPPRESS_EN
    // A digit is visible if it or any higher digit is non-zero; digit 0 is always visible.
    always_comb begin
        logic seen;
        seen      = 1'b0;
        show_mask = '0;
        for (int i = N_DIGITS - 1; i >= 0; i--) begin
            seen         = seen | (active_d[4*i +: 4] != 4'd0);
            show_mask[i] = seen || (i == 0);
        end
    end
`else
    assign show_mask = '1;
`endif

    // Registered outputs derived from the next state, so they line up with state_q.
    always_comb begin
        digit_en_d   = '0;
        digit_code_d = digit_code_q;
        frame_done_d = wrap;
        for (int i = 0; i < N_DIGITS; i++) begin
            digit_en_d[i] = (state_d == StShow) && (idx_d == IdxW'(i)) && show_mask[i];
        end
        // Code changes only at the slot boundary, using freshly committed data on a wrap.
        if (slot_end) begin
            digit_code_d = active_d[{idx_d, 2'b00} +: 4];
        end
    end

    // State and data registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= StBlank;
            cnt_q        <= '0;
            idx_q        <= '0;
            active_q     <= '0;
            shadow_q     <= '0;
            pending_q    <= 1'b0;
            digit_en_q   <= '0;
            digit_code_q <= '0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            active_q     <= active_d;
            shadow_q     <= shadow_d;
            pending_q    <= pending_d;
            digit_en_q   <= digit_en_d;
            digit_code_q <= digit_code_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign load_ready = ~pending_q;
    assign digit_en   = digit_en_q;
    assign digit_code = digit_code_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Bench for display_scan_ctrl with SLOT=10, BLANK_CYCLES=2, N_DIGITS=4.
// k counts clock edges since reset release; all sampling happens on the falling edge.
module tb_display_scan_ctrl;

    logic        clk;
    logic        reset;
    logic        load_valid;
    logic        load_ready;
    logic [15:0] load_data;
    logic [3:0]  digit_code;
    logic [3:0]  digit_en;
    logic        frame_done;

    int n_chk;
    int n_err;
    int k;

    display_scan_ctrl #(
        .CLK_HZ      (100),
        .REFRESH_HZ  (10),
        .N_DIGITS    (4),
        .BLANK_CYCLES(2)
    ) u_dut (
        .clk       (clk),
        .reset     (reset),
        .load_valid(load_valid),
        .load_ready(load_ready),
        .load_data (load_data),
        .digit_code(digit_code),
        .digit_en  (digit_en),
        .frame_done(frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s (k=%0d): got %h expected %h", tag, k, got, exp);
        end
    endtask

    // Visible-digit mask for a committed value.
    function automatic logic [3:0] vis(input logic [15:0] v);
        logic [3:0] m;
        logic       any;
`ifdef LZ_SUPPRESS_EN
        any = 1'b0;
        for (int i = 3; i >= 0; i--) begin
            any  = any | (v[4*i +: 4] != 4'd0);
            m[i] = any || (i == 0);
        end
`else
        any = 1'b1;
        m   = {4{any}};
`endif
        return m;
    endfunction

    // Slot timing: cnt = k%10, SHOW when cnt>=2, digit = (k/10)%4.
    function automatic logic [3:0] exp_en(input int kk, input logic [3:0] mask);
        logic [3:0] one;
        one = 4'b0001;
        if ((kk % 10) >= 2) return (one << ((kk / 10) % 4)) & mask;
        return 4'b0000;
    endfunction

    task automatic tick();
        @(negedge clk);
        k++;
    endtask

    task automatic run_to(input int target, input logic [3:0] mask);
        while (k < target) begin
            tick();
            check("digit_en", {28'd0, digit_en}, {28'd0, exp_en(k, mask)});
            check("frame_done", {31'd0, frame_done}, {31'd0, (k % 40) == 0});
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        n_chk      = 0;
        n_err      = 0;
        k          = 0;
        reset      = 1'b1;
        load_valid = 1'b0;
        load_data  = 16'h0000;

        // 1. Reset defaults.
        repeat (3) @(negedge clk);
        check("rst_en", {28'd0, digit_en}, 32'h0);
        check("rst_code", {28'd0, digit_code}, 32'h0);
        check("rst_ready", {31'd0, load_ready}, 32'h1);
        check("rst_fd", {31'd0, frame_done}, 32'h0);
        reset = 1'b0;
        k     = 0;
        tick();
        check("first_blank", {28'd0, digit_en}, 32'h0);
        tick();
        check("first_show", {28'd0, digit_en}, 32'h1);

        // 2. Free run over two frames.
        run_to(80, vis(16'h0000));
        check("free_code", {28'd0, digit_code}, 32'h0);

        // 3. Load mid-frame, commit at the next frame boundary.
        run_to(85, vis(16'h0000));
        load_valid = 1'b1;
        load_data  = 16'h4321;
        tick();
        check("ld_ready_lo", {31'd0, load_ready}, 32'h0);
        load_valid = 1'b0;
        run_to(119, vis(16'h0000));
        check("ld_ready_hold", {31'd0, load_ready}, 32'h0);
        check("ld_old_code", {28'd0, digit_code}, 32'h0);
        run_to(120, vis(16'h4321));
        check("ld_ready_hi", {31'd0, load_ready}, 32'h1);
        check("ld_code0_blank", {28'd0, digit_code}, 32'h1);
        run_to(125, vis(16'h4321));
        check("ld_code0", {28'd0, digit_code}, 32'h1);
        run_to(135, vis(16'h4321));
        check("ld_code1", {28'd0, digit_code}, 32'h2);
        run_to(145, vis(16'h4321));
        check("ld_code2", {28'd0, digit_code}, 32'h3);
        run_to(155, vis(16'h4321));
        check("ld_code3", {28'd0, digit_code}, 32'h4);

        // 4. Back-pressure: 5555 taken, 6666 waits for the commit.
        load_valid = 1'b1;
        load_data  = 16'h5555;
        tick();
        check("bp_ready_lo", {31'd0, load_ready}, 32'h0);
        load_data = 16'h6666;
        run_to(159, vis(16'h4321));
        check("bp_ready_hold", {31'd0, load_ready}, 32'h0);
        run_to(160, vis(16'h5555));
        check("bp_ready_hi", {31'd0, load_ready}, 32'h1);
        tick();
        check("bp_second_taken", {31'd0, load_ready}, 32'h0);
        load_valid = 1'b0;
        run_to(165, vis(16'h5555));
        check("bp_code_a0", {28'd0, digit_code}, 32'h5);
        run_to(195, vis(16'h5555));
        check("bp_code_a3", {28'd0, digit_code}, 32'h5);
        run_to(205, vis(16'h6666));
        check("bp_code_b0", {28'd0, digit_code}, 32'h6);
        run_to(235, vis(16'h6666));
        check("bp_code_b3", {28'd0, digit_code}, 32'h6);

        // 5. Reset during SHOW of digit 2 with a pending load.
        run_to(245, vis(16'h6666));
        load_valid = 1'b1;
        load_data  = 16'h7777;
        tick();
        check("mr_pending", {31'd0, load_ready}, 32'h0);
        load_valid = 1'b0;
        run_to(265, vis(16'h6666));
        check("mr_digit2", {28'd0, digit_en}, 32'h4);
        #2 reset = 1'b1;
        #1;
        check("mr_en_now", {28'd0, digit_en}, 32'h0);
        check("mr_code_now", {28'd0, digit_code}, 32'h0);
        check("mr_ready_now", {31'd0, load_ready}, 32'h1);
        @(negedge clk);
        reset = 1'b0;
        k     = 0;
        tick();
        check("mr_blank", {28'd0, digit_en}, 32'h0);
        tick();
        check("mr_idx0", {28'd0, digit_en}, 32'h1);
        run_to(45, vis(16'h0000));
        check("mr_no_commit", {28'd0, digit_code}, 32'h0);

        // 6. Leading-zero pattern 0070, then all zeros.
        load_valid = 1'b1;
        load_data  = 16'h0070;
        tick();
        load_valid = 1'b0;
        run_to(80, vis(16'h0000));
        run_to(85, vis(16'h0070));
        check("lz_code0", {28'd0, digit_code}, 32'h0);
        run_to(95, vis(16'h0070));
        check("lz_code1", {28'd0, digit_code}, 32'h7);
        run_to(115, vis(16'h0070));
        check("lz_code3", {28'd0, digit_code}, 32'h0);
        load_valid = 1'b1;
        load_data  = 16'h0000;
        tick();
        load_valid = 1'b0;
        run_to(120, vis(16'h0070));
        run_to(160, vis(16'h0000));
        check("lz_final_code", {28'd0, digit_code}, 32'h0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
